// File: rtl/dregs_sample_writer_if.sv
// Sample-stream and DRegs write-port bundle for the FoFIR delay-register writer.
// master = upstream source / register file side, slave = dregs_sample_writer.
interface dregs_sample_writer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned WIDTH_TAP  = 3
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  dreg_we;
  logic [WIDTH_TAP-1:0]  dreg_waddr;
  logic [DATA_WIDTH-1:0] dreg_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, dreg_we, dreg_waddr, dreg_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, dreg_we, dreg_waddr, dreg_wdata
  );
endinterface

// File: rtl/dregs_sample_writer.sv
// Write-side controller of the DRegs circular file: accepts samples and writes each one
// into the new D0 slot, moving D0 down by one per sample and throttling to one per round.
module dregs_sample_writer #(
  parameter int unsigned NB_TAPS    = 5,
  parameter int unsigned WIDTH_TAP  = (NB_TAPS > 8) ? 4 : 3,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 round_done,
  dregs_sample_writer_if.slave bus,
  output logic                 index_update,
  output logic [WIDTH_TAP-1:0] PD0,
  output logic [WIDTH_TAP-1:0] fill_count,
  output logic                 window_valid
);

  typedef enum logic [1:0] {StFill, StFull, StShift} state_e;

  localparam logic [WIDTH_TAP-1:0] LastSlot = WIDTH_TAP'(NB_TAPS - 1);

  state_e                state;
  logic                  dreg_we;
  logic [WIDTH_TAP-1:0]  dreg_waddr;
  logic [DATA_WIDTH-1:0] dreg_wdata;
  logic                  in_ready;
  logic                  accept;
  logic [WIDTH_TAP-1:0]  pd0_next;

  assign in_ready = (state != StFull);
  assign accept   = bus.in_valid & in_ready;
  // D0 walks downwards so older samples sit at increasing tap offsets from PD0.
  assign pd0_next = (PD0 == '0) ? LastSlot : PD0 - WIDTH_TAP'(1);

  assign bus.in_ready   = in_ready;
  assign bus.dreg_we    = dreg_we;
  assign bus.dreg_waddr = dreg_waddr;
  assign bus.dreg_wdata = dreg_wdata;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state        <= StFill;
      PD0          <= '0;
      fill_count   <= '0;
      dreg_we      <= 1'b0;
      index_update <= 1'b0;
      dreg_waddr   <= '0;
      dreg_wdata   <= '0;
      window_valid <= 1'b0;
    end else begin
      dreg_we      <= accept;
      index_update <= accept;
      if (accept) begin
        PD0        <= pd0_next;
        dreg_waddr <= pd0_next;
        dreg_wdata <= bus.in_data;
      end
      // Next cycle is FULL with no write in flight only when FULL holds without round_done.
      window_valid <= (state == StFull) && !round_done;
      unique case (state)
        StFill: begin
          if (accept) begin
            fill_count <= fill_count + WIDTH_TAP'(1);
            if (fill_count == LastSlot) begin
              state <= StFull;
            end
          end
        end
        StFull: begin
          if (round_done) begin
            state <= StShift;
          end
        end
        StShift: begin
          if (accept) begin
            state <= StFull;
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule
